// File: rtl/lsq_rs_multi_cdb.sv
// In-order load/store queue and reservation station with multi-channel CDB wakeup.
// Define LSQ_MISALIGN_CHK_EN to retire misaligned accesses without a memory request.
module lsq_rs_multi_cdb #(
  parameter int DEPTH   = 8,
  parameter int ROB_W   = 4,
  parameter int NUM_CDB = 3,
  parameter int OP_W    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rollback,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  input  logic                       issue_we,
  input  logic [OP_W-1:0]            op_in,
  input  logic [31:0]                vj_in,
  input  logic [31:0]                vk_in,
  input  logic [ROB_W-1:0]           qj_in,
  input  logic [ROB_W-1:0]           qk_in,
  input  logic [31:0]                offset_in,
  input  logic [ROB_W-1:0]           dest_in,
  input  logic [NUM_CDB-1:0]         cdb_valid,
  input  logic [NUM_CDB*ROB_W-1:0]   cdb_tag,
  input  logic [NUM_CDB*32-1:0]      cdb_data,
  input  logic                       commit_valid,
  input  logic [ROB_W-1:0]           commit_tag,
  output logic                       mem_req_valid,
  output logic                       mem_req_we,
  output logic [OP_W-1:0]            mem_req_op,
  output logic [31:0]                mem_req_addr,
  output logic [31:0]                mem_req_wdata,
  input  logic                       mem_done,
  input  logic [31:0]                mem_rdata,
  output logic                       wb_valid,
  output logic [ROB_W-1:0]           wb_tag,
  output logic [31:0]                wb_data,
  output logic                       wb_exc,
  output logic                       st_misalign
);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;
  state_t state;

  logic             busy [DEPTH];
  logic             cmt  [DEPTH];
  logic [OP_W-1:0]  op   [DEPTH];
  logic [31:0]      vj   [DEPTH];
  logic [31:0]      vk   [DEPTH];
  logic [31:0]      off  [DEPTH];
  logic [ROB_W-1:0] qj   [DEPTH];
  logic [ROB_W-1:0] qk   [DEPTH];
  logic [ROB_W-1:0] dest [DEPTH];
  logic [IDX_W-1:0] head, tail;

  logic             cmt_now [DEPTH];
  logic             keep    [DEPTH];
  logic [32:0]      wk_j    [DEPTH];
  logic [32:0]      wk_k    [DEPTH];
  logic [32:0]      wk_j_in, wk_k_in;
  logic [CNT_W-1:0] kept;
  logic             hd_store, hd_kept, go, mis, retire, issue_ok;
  logic [31:0]      hd_addr;

  // Loop runs high to low so the lowest matching channel overrides.
  function automatic logic [32:0] cdb_lookup(input logic [ROB_W-1:0] q);
    logic [32:0] r;
    r = '0;
    for (int c = NUM_CDB-1; c >= 0; c--)
      if (cdb_valid[c] && q != '0 && cdb_tag[c*ROB_W +: ROB_W] == q)
        r = {1'b1, cdb_data[c*32 +: 32]};
    return r;
  endfunction

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] i, input int n);
    int s;
    s = int'(i) + n;
    if (s >= DEPTH) s = s - DEPTH;
    return IDX_W'(s);
  endfunction

`ifdef LSQ_MISALIGN_CHK_EN
  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'b01:   return a[0];
      2'b10:   return |a;
      default: return 1'b0;
    endcase
  endfunction
`endif

  // Survivors of a rollback: committed stores contiguous from head (same-cycle commit included).
  always_comb begin
    logic             run;
    logic [IDX_W-1:0] idx;
    run  = 1'b1;
    kept = '0;
    idx  = head;
    for (int i = 0; i < DEPTH; i++) begin
      cmt_now[i] = cmt[i] | (commit_valid && busy[i] && op[i][OP_W-1] && dest[i] == commit_tag);
      keep[i]    = 1'b0;
      wk_j[i]    = cdb_lookup(qj[i]);
      wk_k[i]    = cdb_lookup(qk[i]);
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = wrap_add(head, i);
      if (run && busy[idx] && cmt_now[idx]) begin
        keep[idx] = 1'b1;
        kept      = kept + CNT_W'(1);
      end else begin
        run = 1'b0;
      end
    end
    wk_j_in = cdb_lookup(qj_in);
    wk_k_in = cdb_lookup(qk_in);
  end

  assign hd_store = op[head][OP_W-1];
  assign hd_kept  = keep[head];
  assign hd_addr  = vj[head] + off[head];
  assign go       = (state == IDLE) && busy[head] && (qj[head] == '0) &&
                    (hd_store ? (qk[head] == '0 && cmt[head]) : !rollback);
`ifdef LSQ_MISALIGN_CHK_EN
  assign mis = misaligned(op[head][1:0], hd_addr[1:0]);
`else
  assign mis = 1'b0;
`endif
  assign retire   = (state == BUSY && mem_done) || (go && mis);
  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign issue_ok = issue_we && !full && !rollback;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      mem_req_valid <= 1'b0;
      mem_req_we    <= 1'b0;
      mem_req_op    <= '0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
      wb_valid      <= 1'b0;
      wb_tag        <= '0;
      wb_data       <= '0;
      wb_exc        <= 1'b0;
      st_misalign   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        busy[i] <= 1'b0;
        cmt[i]  <= 1'b0;
        op[i]   <= '0;
        vj[i]   <= '0;
        vk[i]   <= '0;
        off[i]  <= '0;
        qj[i]   <= '0;
        qk[i]   <= '0;
        dest[i] <= '0;
      end
    end else begin
      wb_valid    <= 1'b0;
      wb_tag      <= '0;
      wb_data     <= '0;
      wb_exc      <= 1'b0;
      st_misalign <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        cmt[i] <= cmt_now[i];
        if (busy[i] && wk_j[i][32]) begin
          vj[i] <= wk_j[i][31:0];
          qj[i] <= '0;
        end
        if (busy[i] && wk_k[i][32]) begin
          vk[i] <= wk_k[i][31:0];
          qk[i] <= '0;
        end
        if (rollback && !keep[i]) begin
          busy[i] <= 1'b0;
          cmt[i]  <= 1'b0;
        end
      end
      if (rollback) begin
        tail  <= wrap_add(head, int'(kept));
        count <= kept - CNT_W'(retire && hd_kept);
      end else begin
        if (issue_ok) begin
          busy[tail] <= 1'b1;
          cmt[tail]  <= 1'b0;
          op[tail]   <= op_in;
          vj[tail]   <= wk_j_in[32] ? wk_j_in[31:0] : vj_in;
          qj[tail]   <= wk_j_in[32] ? '0 : qj_in;
          vk[tail]   <= wk_k_in[32] ? wk_k_in[31:0] : vk_in;
          qk[tail]   <= wk_k_in[32] ? '0 : qk_in;
          off[tail]  <= offset_in;
          dest[tail] <= dest_in;
          tail       <= wrap_add(tail, 1);
        end
        count <= count + CNT_W'(issue_ok) - CNT_W'(retire);
      end
      if (retire && (!rollback || hd_kept)) begin
        busy[head] <= 1'b0;
        cmt[head]  <= 1'b0;
        head       <= wrap_add(head, 1);
      end

      // Head execution FSM
      case (state)
        IDLE: if (go) begin
          if (mis) begin
            if (hd_store) st_misalign <= 1'b1;
            else begin
              wb_valid <= 1'b1;
              wb_exc   <= 1'b1;
              wb_tag   <= dest[head];
            end
          end else begin
            state         <= BUSY;
            mem_req_valid <= 1'b1;
            mem_req_we    <= hd_store;
            mem_req_op    <= op[head];
            mem_req_addr  <= hd_addr;
            mem_req_wdata <= vk[head];
          end
        end
        BUSY: if (mem_done) begin
          state         <= IDLE;
          mem_req_valid <= 1'b0;
          mem_req_we    <= 1'b0;
          mem_req_op    <= '0;
          mem_req_addr  <= '0;
          mem_req_wdata <= '0;
          if (!hd_store && !rollback) begin
            wb_valid <= 1'b1;
            wb_tag   <= dest[head];
            wb_data  <= mem_rdata;
          end
        end else if (rollback && !hd_store) begin
          state <= DRAIN;
        end
        DRAIN: if (mem_done) begin
          state         <= IDLE;
          mem_req_valid <= 1'b0;
          mem_req_we    <= 1'b0;
          mem_req_op    <= '0;
          mem_req_addr  <= '0;
          mem_req_wdata <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsq_rs_multi_cdb.sv
// Directed table-driven bench for lsq_rs_multi_cdb plus hand-written multi-cycle sequences.
// Sequence 6 follows LSQ_MISALIGN_CHK_EN when it is defined.
module tb_lsq_rs_multi_cdb;
  logic        clk = 1'b0;
  logic        rst, rollback, full, empty, issue_we, commit_valid;
  logic [3:0]  count, op_in, qj_in, qk_in, dest_in, commit_tag, mem_req_op, wb_tag;
  logic [31:0] vj_in, vk_in, offset_in, mem_req_addr, mem_req_wdata, mem_rdata, wb_data;
  logic [2:0]  cdb_valid;
  logic [11:0] cdb_tag;
  logic [95:0] cdb_data;
  logic        mem_req_valid, mem_req_we, mem_done, wb_valid, wb_exc, st_misalign;

  int checks = 0;
  int errors = 0;

  localparam logic [3:0] LW = 4'b0010, SW = 4'b1010, LH = 4'b0001;

  lsq_rs_multi_cdb dut (
    .clk(clk), .rst(rst), .rollback(rollback), .full(full), .empty(empty), .count(count),
    .issue_we(issue_we), .op_in(op_in), .vj_in(vj_in), .vk_in(vk_in), .qj_in(qj_in),
    .qk_in(qk_in), .offset_in(offset_in), .dest_in(dest_in), .cdb_valid(cdb_valid),
    .cdb_tag(cdb_tag), .cdb_data(cdb_data), .commit_valid(commit_valid),
    .commit_tag(commit_tag), .mem_req_valid(mem_req_valid), .mem_req_we(mem_req_we),
    .mem_req_op(mem_req_op), .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_tag(wb_tag),
    .wb_data(wb_data), .wb_exc(wb_exc), .st_misalign(st_misalign)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        iss;
    logic [3:0]  op;
    logic [31:0] vj;
    logic [3:0]  qj, qk;
    logic [31:0] off;
    logic [3:0]  dest;
    logic [2:0]  cv;
    logic [11:0] ct;
    logic [95:0] cd;
    logic        cmv;
    logic [3:0]  ctag;
    logic        done;
    logic [31:0] rdata;
    logic        e_req, e_we;
    logic [31:0] e_addr, e_wdt;
    logic        e_wb;
    logic [3:0]  e_tag;
    logic [31:0] e_wbd;
    logic [3:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic iss, input logic [3:0] op, input logic [31:0] vj,
                     input logic [3:0] qj, input logic [3:0] qk, input logic [31:0] off,
                     input logic [3:0] dest, input logic [2:0] cv, input logic [11:0] ct,
                     input logic [95:0] cd, input logic cmv, input logic [3:0] ctag,
                     input logic done, input logic [31:0] rdata, input logic e_req,
                     input logic e_we, input logic [31:0] e_addr, input logic [31:0] e_wdt,
                     input logic e_wb, input logic [3:0] e_tag, input logic [31:0] e_wbd,
                     input logic [3:0] e_cnt);
    vec_t v;
    v.iss = iss; v.op = op; v.vj = vj; v.qj = qj; v.qk = qk; v.off = off; v.dest = dest;
    v.cv = cv; v.ct = ct; v.cd = cd; v.cmv = cmv; v.ctag = ctag; v.done = done;
    v.rdata = rdata; v.e_req = e_req; v.e_we = e_we; v.e_addr = e_addr; v.e_wdt = e_wdt;
    v.e_wb = e_wb; v.e_tag = e_tag; v.e_wbd = e_wbd; v.e_cnt = e_cnt;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rollback = 0; issue_we = 0; op_in = 0; vj_in = 0; vk_in = 0; qj_in = 0; qk_in = 0;
    offset_in = 0; dest_in = 0; cdb_valid = 0; cdb_tag = 0; cdb_data = 0;
    commit_valid = 0; commit_tag = 0; mem_done = 0; mem_rdata = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] vj, input logic [31:0] vk,
                       input logic [3:0] dest);
    issue_we = 1; op_in = op; vj_in = vj; vk_in = vk; qj_in = 0; qk_in = 0;
    offset_in = 0; dest_in = dest;
  endtask

  // Wait (bounded) for the request, check it, complete it and check the writeback.
  task automatic serve(input string nm, input logic [31:0] addr, input logic we,
                       input logic [3:0] tag, input logic [31:0] rdata);
    int n;
    n = 0;
    while (!mem_req_valid && n < 12) begin
      tick();
      n++;
    end
    chk({nm, " req_valid"}, mem_req_valid, 1);
    chk({nm, " req_addr"}, mem_req_addr, addr);
    chk({nm, " req_we"}, mem_req_we, we);
    mem_done = 1; mem_rdata = rdata;
    tick();
    mem_done = 0; mem_rdata = 0;
    chk({nm, " wb_valid"}, wb_valid, !we);
    if (!we) begin
      chk({nm, " wb_tag"}, wb_tag, tag);
      chk({nm, " wb_data"}, wb_data, rdata);
    end
  endtask

  initial begin
    // Sequence 1: load, 2: store with two-channel wakeup and commit, then lowest-channel priority.
    add(1, LW, 32'h100, 0, 0, 4, 3, 0, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,             1, 0, 32'h104, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,             1, 0, 32'h104, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,             1, 0, 32'h104, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hCAFE,      0, 0, 0, 0, 1, 3, 32'hCAFE, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 0, 0, 0, 0);
    add(1, SW, 0, 5, 6, 0, 7, 0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 3'b101, 12'h506, {32'h200, 32'h0, 32'h77}, 0, 0, 0, 0,
        0, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0,             0, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,             1, 1, 32'h200, 32'h77, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,             0, 0, 0, 0, 0, 0, 0, 0);
    add(1, LW, 0, 9, 0, 0, 2, 3'b110, 12'h990, {32'h400, 32'h300, 32'h0}, 0, 0, 0, 0,
        0, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,             1, 0, 32'h300, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h55,        0, 0, 0, 0, 1, 2, 32'h55, 0);

    do_reset();
    chk("reset count", count, 0);
    chk("reset empty", empty, 1);
    chk("reset full", full, 0);
    chk("reset req_valid", mem_req_valid, 0);
    chk("reset wb_valid", wb_valid, 0);
    chk("reset wb_exc", wb_exc, 0);
    chk("reset st_misalign", st_misalign, 0);

    foreach (vecs[i]) begin
      issue_we = vecs[i].iss; op_in = vecs[i].op; vj_in = vecs[i].vj; vk_in = 0;
      qj_in = vecs[i].qj; qk_in = vecs[i].qk; offset_in = vecs[i].off; dest_in = vecs[i].dest;
      cdb_valid = vecs[i].cv; cdb_tag = vecs[i].ct; cdb_data = vecs[i].cd;
      commit_valid = vecs[i].cmv; commit_tag = vecs[i].ctag;
      mem_done = vecs[i].done; mem_rdata = vecs[i].rdata;
      tick();
      chk($sformatf("v%0d req_valid", i), mem_req_valid, vecs[i].e_req);
      if (vecs[i].e_req) begin
        chk($sformatf("v%0d req_addr", i), mem_req_addr, vecs[i].e_addr);
        chk($sformatf("v%0d req_we", i), mem_req_we, vecs[i].e_we);
        if (vecs[i].e_we) chk($sformatf("v%0d req_wdata", i), mem_req_wdata, vecs[i].e_wdt);
      end
      chk($sformatf("v%0d wb_valid", i), wb_valid, vecs[i].e_wb);
      if (vecs[i].e_wb) begin
        chk($sformatf("v%0d wb_tag", i), wb_tag, vecs[i].e_tag);
        chk($sformatf("v%0d wb_data", i), wb_data, vecs[i].e_wbd);
      end
      chk($sformatf("v%0d count", i), count, vecs[i].e_cnt);
    end
    idle_inputs();

    // Sequence 3: fill, drop on full, wrap the tail, issue alongside retire.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      issue(LW, 32'h1000 + 32'(i) * 32'h10, 0, 4'(i + 1));
      tick();
      chk($sformatf("fill%0d count", i), count, i + 1);
    end
    chk("fill full", full, 1);
    chk("fill head req_addr", mem_req_addr, 32'h1000);
    issue(LW, 32'h9000, 0, 9);
    tick();
    chk("drop count", count, 8);
    chk("drop full", full, 1);
    issue_we = 0; mem_done = 1; mem_rdata = 32'h11;
    tick();
    mem_done = 0;
    chk("retire1 count", count, 7);
    chk("retire1 wb_tag", wb_tag, 1);
    issue(LW, 32'hA000, 0, 10);
    tick();
    issue_we = 0;
    chk("wrap count", count, 8);
    chk("wrap full", full, 1);
    chk("head2 req_addr", mem_req_addr, 32'h1010);
    mem_done = 1; mem_rdata = 32'h22;
    tick();
    mem_done = 0;
    chk("retire2 count", count, 7);
    tick();
    chk("head3 req_valid", mem_req_valid, 1);
    issue(LW, 32'hB000, 0, 11);
    mem_done = 1; mem_rdata = 32'h33;
    tick();
    issue_we = 0; mem_done = 0;
    chk("issue+retire count", count, 7);
    chk("issue+retire wb_tag", wb_tag, 3);
    for (int i = 4; i <= 8; i++)
      serve($sformatf("drain%0d", i), 32'h1000 + 32'(i - 1) * 32'h10, 0, 4'(i), 32'(i));
    serve("drain_wrap", 32'hA000, 0, 10, 32'hAA);
    serve("drain_last", 32'hB000, 0, 11, 32'hBB);
    chk("drain empty", empty, 1);

    // Sequence 4a: rollback keeps two committed stores; tail lands at head+2.
    do_reset();
    issue(SW, 32'h40, 1, 1);
    tick();
    issue(SW, 32'h44, 2, 2); commit_valid = 1; commit_tag = 1;
    tick();
    issue(LW, 32'h300, 0, 3); commit_tag = 2;
    tick();
    commit_valid = 0;
    issue(LW, 32'h304, 0, 4);
    tick();
    issue(LW, 32'h308, 0, 5);
    tick();
    chk("pre_rb count", count, 5);
    issue_we = 0; rollback = 1;
    tick();
    rollback = 0;
    chk("rb count", count, 2);
    chk("rb store req_addr", mem_req_addr, 32'h40);
    issue(LW, 32'h600, 0, 6);
    tick();
    issue_we = 0;
    chk("post_rb count", count, 3);
    serve("rb_st1", 32'h40, 1, 1, 0);
    serve("rb_st2", 32'h44, 1, 2, 0);
    serve("rb_ld", 32'h600, 0, 6, 32'h66);
    chk("rb empty", empty, 1);

    // Sequence 4b: rollback during an in-flight load drains without writeback.
    do_reset();
    issue(LW, 32'h700, 0, 7);
    tick();
    issue_we = 0;
    tick();
    chk("drain req_valid", mem_req_valid, 1);
    rollback = 1;
    tick();
    rollback = 0;
    chk("drain count", count, 0);
    chk("drain held req", mem_req_valid, 1);
    tick();
    chk("drain still held", mem_req_valid, 1);
    mem_done = 1; mem_rdata = 32'hBAD;
    tick();
    mem_done = 0;
    chk("drain done req", mem_req_valid, 0);
    chk("drain no wb", wb_valid, 0);
    tick();
    chk("drain no wb later", wb_valid, 0);
    issue(LW, 32'h800, 0, 8);
    tick();
    issue_we = 0;
    serve("after_drain", 32'h800, 0, 8, 32'h88);

    // Sequence 5: asynchronous reset between edges while BUSY.
    do_reset();
    issue(LW, 32'h900, 0, 9);
    tick();
    issue_we = 0;
    tick();
    chk("arst pre req", mem_req_valid, 1);
    #3 rst = 1;
    #1;
    chk("arst req_valid", mem_req_valid, 0);
    chk("arst req_addr", mem_req_addr, 0);
    chk("arst count", count, 0);
    chk("arst empty", empty, 1);
    #1 rst = 0;
    mem_done = 1; mem_rdata = 32'h99;
    tick();
    mem_done = 0;
    chk("arst late done wb", wb_valid, 0);
    chk("arst late done req", mem_req_valid, 0);
    chk("arst late count", count, 0);

    // Sequence 6: misaligned halfword load and word store.
    do_reset();
    issue(LH, 32'h101, 0, 10);
    tick();
    issue_we = 0;
`ifdef LSQ_MISALIGN_CHK_EN
    tick();
    chk("mis ld req", mem_req_valid, 0);
    chk("mis ld wb_valid", wb_valid, 1);
    chk("mis ld wb_exc", wb_exc, 1);
    chk("mis ld wb_data", wb_data, 0);
    chk("mis ld wb_tag", wb_tag, 10);
    chk("mis ld count", count, 0);
    issue(SW, 32'h102, 5, 11);
    tick();
    issue_we = 0; commit_valid = 1; commit_tag = 11;
    tick();
    commit_valid = 0;
    tick();
    chk("mis st pulse", st_misalign, 1);
    chk("mis st req", mem_req_valid, 0);
    chk("mis st count", count, 0);
    tick();
    chk("mis st pulse end", st_misalign, 0);
`else
    serve("lh_unaligned", 32'h101, 0, 10, 32'h1234);
    chk("lh wb_exc", wb_exc, 0);
    chk("lh st_misalign", st_misalign, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
